// File: rtl/axi_mem_bridge_if.sv
// ============================================================================
// Module      : axi_mem_bridge_if
// Description : Cache-side memory port plus 32-bit AXI3 master bus grouped for
//               axi_mem_bridge. master = the bridge, slave = CPU/AXI fabric.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_mem_bridge_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
);
  // cache-side request/response
  logic [ADDR_W-1:0] mem_a;
  logic              mem_access;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_st_data;
  logic [31:0]       mem_data;
  logic              mem_ready;
  logic              flush;

  // read address / read data
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // write address / write data / write response
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data, flush,
    output mem_data, mem_ready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data, flush,
    input  mem_data, mem_ready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

`default_nettype wire

// File: rtl/axi_mem_bridge.sv
// ============================================================================
// Module      : axi_mem_bridge
// Description : Single-outstanding cache-port to AXI3 bridge, one beat per
//               request, with flush cancellation. Optional macro
//               AXI_ADDR_MAP_EN clears addr[31:29] (kseg0/kseg1 -> physical).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_mem_bridge #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  axi_mem_bridge_if.master bus
);

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WREQ = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              cancel_q, cancel_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic [ADDR_W-1:0] axi_addr;
  logic              arvalid, rready, awvalid, wvalid, bready;
  logic              aw_hs, w_hs;
  logic              unused_ok;

  assign arvalid = (state_q == S_AR);
  assign rready  = (state_q == S_R);
  assign awvalid = (state_q == S_WREQ) && !aw_done_q;
  assign wvalid  = (state_q == S_WREQ) && !w_done_q;
  assign bready  = (state_q == S_B);
  assign aw_hs   = awvalid && bus.awready;
  assign w_hs    = wvalid && bus.wready;

`ifdef AXI_ADDR_MAP_EN
  assign axi_addr  = {3'b000, addr_q[ADDR_W-4:0]};
  assign unused_ok = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp,
                       addr_q[ADDR_W-1:ADDR_W-3]};
`else
  assign axi_addr  = addr_q;
  assign unused_ok = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cancel_d  = cancel_q || (bus.flush && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (bus.mem_access && !bus.flush) begin
          addr_d  = bus.mem_a;
          size_d  = bus.mem_size;
          sel_d   = bus.mem_sel;
          wdata_d = bus.mem_st_data;
          state_d = bus.mem_write ? S_WREQ : S_AR;
        end
      end
      S_AR: begin
        if (bus.arready) state_d = S_R;
      end
      S_R: begin
        if (bus.rvalid) begin
          rdata_d = bus.rdata;
          state_d = cancel_d ? S_IDLE : S_DONE;
        end
      end
      S_WREQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // A cancelled write still owes the slave its B handshake
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        if (bus.bvalid) state_d = cancel_d ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) cancel_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cancel_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cancel_q  <= cancel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign bus.mem_data  = rdata_q;
  assign bus.mem_ready = (state_q == S_DONE);

  assign bus.arid    = {ID_W{1'b0}};
  assign bus.araddr  = axi_addr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = BURST_INCR;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = arvalid;
  assign bus.rready  = rready;

  assign bus.awid    = {ID_W{1'b0}};
  assign bus.awaddr  = axi_addr;
  assign bus.awlen   = 4'd0;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = BURST_INCR;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = awvalid;
  assign bus.wid     = {ID_W{1'b0}};
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = sel_q;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wvalid;
  assign bus.bready  = bready;

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_bridge.sv
// ============================================================================
// Module      : tb_axi_mem_bridge
// Description : Scoreboard bench for axi_mem_bridge with a directed CPU driver
//               and a delay-programmable AXI slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_mem_bridge;

  logic clk;
  logic resetn;

  axi_mem_bridge_if #(.ID_W(4), .ADDR_W(32)) bus ();

  axi_mem_bridge #(.ID_W(4), .ADDR_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int n_ready = 0;
  int n_ar    = 0;

  logic [32:0] exp_resp[$];   // {is_read, data}
  logic [44:0] exp_ar[$];     // {arburst, arlen, arsize, araddr}
  logic [40:0] exp_aw[$];     // {awburst, awlen, awsize, awaddr}
  logic [40:0] exp_w[$];      // {wid, wlast, wstrb, wdata}

  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] rd_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] phys(input logic [31:0] a);
`ifdef AXI_ADDR_MAP_EN
    return {3'b000, a[28:0]};
`else
    return a;
`endif
  endfunction

  // AXI slave: read side
  initial begin : slave_rd
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    bus.rid = '0; bus.rresp = '0; bus.rlast = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn && bus.arvalid) begin
        repeat (ar_delay) @(negedge clk);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        repeat (r_delay) @(negedge clk);
        bus.rdata  = rd_data;
        bus.rvalid = 1'b1;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
      end
    end
  end

  // AXI slave: write side
  initial begin : slave_wr
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    bus.bid = '0; bus.bresp = '0;
    forever begin
      @(negedge clk);
      if (resetn && bus.awvalid) begin
        fork
          begin
            repeat (aw_delay) @(negedge clk);
            bus.awready = 1'b1;
            @(negedge clk);
            bus.awready = 1'b0;
          end
          begin
            repeat (w_delay) @(negedge clk);
            bus.wready = 1'b1;
            @(negedge clk);
            bus.wready = 1'b0;
          end
        join
        repeat (b_delay) @(negedge clk);
        bus.bvalid = 1'b1;
        @(negedge clk);
        bus.bvalid = 1'b0;
      end
    end
  end

  // Monitor: compares every DUT-presented event against the scoreboard queues
  initial begin : monitor
    logic prev_arv, prev_arhs, prev_awv, prev_awhs, prev_wv, prev_whs;
    logic [32:0] e;
    prev_arv = 0; prev_arhs = 0; prev_awv = 0; prev_awhs = 0; prev_wv = 0; prev_whs = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        prev_arv = 0; prev_awv = 0; prev_wv = 0;
      end else begin
        if (prev_arv && !prev_arhs) check("arvalid_hold", 64'(bus.arvalid), 64'd1);
        if (prev_awv && !prev_awhs) check("awvalid_hold", 64'(bus.awvalid), 64'd1);
        if (prev_wv && !prev_whs)   check("wvalid_hold", 64'(bus.wvalid), 64'd1);

        if (bus.mem_ready) begin
          n_ready++;
          if (exp_resp.size() == 0) begin
            check("unexpected_mem_ready", 64'(bus.mem_ready), 64'd0);
          end else begin
            e = exp_resp.pop_front();
            if (e[32]) check("mem_data", 64'(bus.mem_data), 64'(e[31:0]));
          end
        end
        if (bus.arvalid && bus.arready) begin
          n_ar++;
          if (exp_ar.size() == 0) check("unexpected_ar", 64'(bus.araddr), 64'hFFFF_FFFF_FFFF_FFFF);
          else check("ar_fields", 64'({bus.arburst, bus.arlen, bus.arsize, bus.araddr}),
                     64'(exp_ar.pop_front()));
        end
        if (bus.awvalid && bus.awready) begin
          if (exp_aw.size() == 0) check("unexpected_aw", 64'(bus.awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
          else check("aw_fields", 64'({bus.awburst, bus.awlen, bus.awsize, bus.awaddr}),
                     64'(exp_aw.pop_front()));
        end
        if (bus.wvalid && bus.wready) begin
          if (exp_w.size() == 0) check("unexpected_w", 64'(bus.wdata), 64'hFFFF_FFFF_FFFF_FFFF);
          else check("w_fields", 64'({bus.wid, bus.wlast, bus.wstrb, bus.wdata}),
                     64'(exp_w.pop_front()));
        end
        prev_arv  = bus.arvalid; prev_arhs = bus.arvalid && bus.arready;
        prev_awv  = bus.awvalid; prev_awhs = bus.awvalid && bus.awready;
        prev_wv   = bus.wvalid;  prev_whs  = bus.wvalid && bus.wready;
      end
    end
  end

  task automatic drive(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic [3:0] sel, input logic [31:0] d);
    bus.mem_a = a; bus.mem_write = wr; bus.mem_size = sz;
    bus.mem_sel = sel; bus.mem_st_data = d; bus.mem_access = 1'b1;
  endtask

  // Issue a request at a negedge and hold it until mem_ready; returns latency
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [3:0] sel, input logic [31:0] d, output int lat);
    @(negedge clk);
    drive(wr, a, sz, sel, d);
    lat = 0;
    forever begin
      #2;
      if (bus.mem_ready) break;
      if (lat >= 60) begin
        check("req_timeout", 64'(lat), 64'd0);
        break;
      end
      lat++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.mem_access = 1'b0;
  endtask

  task automatic wait_for_rready();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #2;
      if (bus.rready) break;
      if (++n > 40) begin
        check("rready_timeout", 64'(n), 64'd0);
        break;
      end
    end
  endtask

  initial begin : stim
    int lat;
    int n;
    bus.mem_a = '0; bus.mem_access = 1'b0; bus.mem_write = 1'b0; bus.mem_size = '0;
    bus.mem_sel = '0; bus.mem_st_data = '0; bus.flush = 1'b0;
    resetn = 1'b0;

    // Reset state
    @(negedge clk); #2;
    check("reset_valids", 64'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                               bus.bready, bus.mem_ready}), 64'd0);
    check("reset_mem_data", 64'(bus.mem_data), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Word read, zero-wait slave
    rd_data = 32'h3C1D_BFC0;
    exp_ar.push_back({2'b01, 8'd0, 3'b010, phys(32'hBFC0_0000)});
    exp_resp.push_back({1'b1, 32'h3C1D_BFC0});
    do_req(1'b0, 32'hBFC0_0000, 2'b10, 4'b1111, 32'h0, lat);
    check("read_latency", 64'(lat), 64'd3);

    // Byte store, wready three cycles after awready
    aw_delay = 0; w_delay = 3;
    exp_aw.push_back({2'b01, 4'd0, 3'b000, phys(32'hA000_1002)});
    exp_w.push_back({4'd0, 1'b1, 4'b0100, 32'h00AB_0000});
    exp_resp.push_back({1'b0, 32'h0});
    @(negedge clk);
    drive(1'b1, 32'hA000_1002, 2'b00, 4'b0100, 32'h00AB_0000);
    n = 0;
    forever begin
      #2;
      if (bus.awvalid && bus.awready) begin
        @(negedge clk); #2;
        check("aw_drops_w_holds", 64'({bus.awvalid, bus.wvalid}), 64'b01);
        break;
      end
      if (++n > 20) begin
        check("aw_timeout", 64'(n), 64'd0);
        break;
      end
      @(negedge clk);
    end
    n = 0;
    while (!bus.mem_ready && n < 40) begin
      @(negedge clk); #2;
      n++;
    end
    check("store_done", 64'(bus.mem_ready), 64'd1);
    @(posedge clk); #1 bus.mem_access = 1'b0;
    w_delay = 0;

    // Word store, zero-wait slave
    exp_aw.push_back({2'b01, 4'd0, 3'b010, phys(32'h8000_1000)});
    exp_w.push_back({4'd0, 1'b1, 4'b1111, 32'hDEAD_BEEF});
    exp_resp.push_back({1'b0, 32'h0});
    do_req(1'b1, 32'h8000_1000, 2'b10, 4'b1111, 32'hDEAD_BEEF, lat);
    check("write_latency", 64'(lat), 64'd3);

    // Flush while AR stalls for two cycles: read completes on AXI, never reported
    ar_delay = 2; rd_data = 32'h5555_AAAA;
    exp_ar.push_back({2'b01, 8'd0, 3'b001, phys(32'h8000_2000)});
    @(negedge clk);
    drive(1'b0, 32'h8000_2000, 2'b01, 4'b0011, 32'h0);
    @(negedge clk);
    bus.flush = 1'b1; bus.mem_access = 1'b0;
    repeat (2) @(negedge clk);
    bus.flush = 1'b0;
    repeat (6) @(negedge clk);
    ar_delay = 0;

    // Next request accepted afterwards
    rd_data = 32'h1234_5678;
    exp_ar.push_back({2'b01, 8'd0, 3'b010, phys(32'h0000_0010)});
    exp_resp.push_back({1'b1, 32'h1234_5678});
    do_req(1'b0, 32'h0000_0010, 2'b10, 4'b1111, 32'h0, lat);
    check("post_flush_latency", 64'(lat), 64'd3);

    // Flush in IDLE alongside a request: nothing accepted
    @(negedge clk);
    drive(1'b0, 32'h8000_3000, 2'b10, 4'b1111, 32'h0);
    bus.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("idle_flush_no_launch", 64'({bus.arvalid, bus.awvalid}), 64'd0);
      @(negedge clk);
    end
    bus.flush = 1'b0; bus.mem_access = 1'b0;

    // Flush in the same cycle as the R handshake: cancel wins
    rd_data = 32'hCAFE_F00D;
    exp_ar.push_back({2'b01, 8'd0, 3'b010, phys(32'h8000_4000)});
    @(negedge clk);
    drive(1'b0, 32'h8000_4000, 2'b10, 4'b1111, 32'h0);
    wait_for_rready();
    bus.flush = 1'b1; bus.mem_access = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset while in R
    r_delay = 3; rd_data = 32'h0BAD_0BAD;
    exp_ar.push_back({2'b01, 8'd0, 3'b010, phys(32'h8000_5000)});
    @(negedge clk);
    drive(1'b0, 32'h8000_5000, 2'b10, 4'b1111, 32'h0);
    wait_for_rready();
    #1 resetn = 1'b0;
    #1;
    check("async_reset_valids", 64'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                                     bus.bready, bus.mem_ready}), 64'd0);
    check("async_reset_mem_data", 64'(bus.mem_data), 64'd0);
    bus.mem_access = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    r_delay = 0;

    rd_data = 32'h7654_3210;
    exp_ar.push_back({2'b01, 8'd0, 3'b000, phys(32'h9FC0_0003)});
    exp_resp.push_back({1'b1, 32'h7654_3210});
    do_req(1'b0, 32'h9FC0_0003, 2'b00, 4'b1000, 32'h0, lat);
    check("post_reset_latency", 64'(lat), 64'd3);

    repeat (4) @(negedge clk);
    check("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
    check("ar_queue_empty", 64'(exp_ar.size() + exp_aw.size() + exp_w.size()), 64'd0);
    check("mem_ready_count", 64'(n_ready), 64'd5);
    check("ar_handshake_count", 64'(n_ar), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/axi_mem_bridge.md
Name: axi_mem_bridge

Overview:
- Single-outstanding bridge from the CPU's cache-side memory port (I/D cache mux output) to a 32-bit AXI3 master.
- Sits directly downstream of the i_cache/d_cache arbitration mux in mycpu_top; one beat per request.
- Returns registered read data and a one-cycle mem_ready pulse.
- Supports exception flush: a cancelled transfer still completes legally on AXI but is never reported to the requester.

Parameters:
ID_W, 4, AXI id width; all ids are driven to 0
ADDR_W, 32, address width

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
mem_a  input  32  request byte address
mem_access  input  1  request valid; requester holds it until mem_ready
mem_write  input  1  1 = store, 0 = load
mem_size  input  2  00 byte, 01 half, 10 word
mem_sel  input  4  byte strobes for stores
mem_st_data  input  32  store data
mem_data  output  32  load data, valid while mem_ready=1
mem_ready  output  1  one-cycle completion pulse
flush  input  1  cancel the current or incoming request
arid/arlen/arburst/arlock/arcache/arprot  output  ID_W/8/2/2/4/3  constants 0/0/01/0/0/0
araddr, arsize, arvalid  output  32,3,1  read address channel
arready  input  1  read address accept
rid, rresp, rlast  input  ID_W,2,1  ignored
rdata, rvalid  input  32,1  read data channel
rready  output  1  read data accept
awid/awlen/awburst/awlock/awcache/awprot  output  ID_W/4/2/2/4/3  constants 0/0/01/0/0/0
awaddr, awsize, awvalid  output  32,3,1  write address channel
awready  input  1  write address accept
wid, wdata, wstrb, wlast, wvalid  output  ID_W,32,4,1,1  write data channel; wid=0, wlast=1
wready  input  1  write data accept
bid, bresp  input  ID_W,2  ignored
bvalid  input  1  write response valid
bready  output  1  write response accept

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous and active-low.
- Reset: state=IDLE.
  - All valid/ready outputs = 0.
  - mem_data = 0.
  - Cancel flag and handshake flags cleared.
  - Reset mid-transfer abandons it immediately.
- IDLE: when mem_access=1 and flush=0, latch address, size, sel, store data and write.
  - Read goes to AR; write goes to WREQ.
  - If flush=1, nothing is accepted.
- Latched fields drive the AXI outputs:
  - arsize = awsize = {1'b0, size}.
  - wstrb = sel.
  - araddr/awaddr = latched address (see optional feature).
- AR: arvalid=1 until arready, then go to R. arvalid never drops before its handshake.
- R: rready=1. On rvalid, register rdata into mem_data, then go to DONE (or to IDLE if cancelled).
- WREQ: awvalid and wvalid assert together.
  - Each channel drops independently after its own handshake; aw_done and w_done are tracked separately.
  - When both are done (same cycle allowed), go to B.
- B: bready=1. On bvalid, go to DONE (or to IDLE if cancelled).
- DONE: mem_ready=1 for exactly one cycle, then IDLE.
  - New requests are accepted only in IDLE, so a still-held mem_access in DONE never relaunches.
- Latency with zero-wait slave, request in cycle 0:
  - Read: arvalid in cycle 1, rready in cycle 2, mem_ready in cycle 3.
  - Write: mem_ready in cycle 3.
- Flush in any non-IDLE state sets cancel:
  - The AXI transaction runs to its handshake.
  - DONE is skipped and mem_ready stays 0.
  - Cancel clears on entry to IDLE.
  - Flush in DONE does not suppress that cycle's mem_ready.
- Simultaneous flush and completion handshake: cancel wins, no mem_ready.

Optional Feature:
AXI_ADDR_MAP_EN:
- Defined: araddr/awaddr = {3'b000, addr[28:0]}, mapping kseg0/kseg1 to physical addresses.
- Undefined: the address passes through unchanged.

Test Plan:
- Read, mem_a=0xBFC00000, word, slave arready=1, rvalid next cycle with rdata=0x3C1DBFC0 -> arsize=010; mem_ready pulses once with mem_data=0x3C1DBFC0. With the macro defined, araddr=0x1FC00000.
- Store byte, mem_sel=0100, data=0x00AB0000; wready arrives 3 cycles after awready -> awvalid drops first, wvalid holds; wstrb=0100, awsize=000; one mem_ready after bvalid.
- Flush asserted while arvalid=1 and arready=0 for 2 cycles -> arvalid stays high until handshake; the read completes on AXI; mem_ready never asserts; the next request is accepted afterwards.
- mem_access held high through DONE -> exactly one AR handshake and one mem_ready per request.
- resetn dropped while in R -> all outputs go to 0 asynchronously; after release, a new read completes normally.
